// File: rtl/lau_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lau_pkg
// Purpose  : Shared types for the logic/arithmetic unit blocks.
//            speed_e - prefix-tree topology selector for PrefixAndOr
//            pao_state_e - operand-tracking state of prefix_and_or_serial
// Revision : 1.0 - initial release
// ============================================================================
package lau_pkg;

  // Prefix-tree topology: SLOW = ripple chain, MEDIUM = Sklansky,
  // FAST = Kogge-Stone.
  typedef enum logic [1:0] {
    SLOW   = 2'd0,
    MEDIUM = 2'd1,
    FAST   = 2'd2
  } speed_e;

  // IDLE: the next accepted beat starts a new operand.
  // BUSY: a multi-beat operand is in progress; carry/pacc are live.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } pao_state_e;

endpackage : lau_pkg
`default_nettype wire

// File: rtl/PrefixAndOr.sv
`default_nettype none
// ============================================================================
// Module   : PrefixAndOr
// Purpose  : Combinational group prefix of (generate, propagate) pairs.
//            GT[i] = G[i] | P[i]&G[i-1] | ... ;  PT[i] = &P[i:0]
// Ports    : GI [width-1:0] in  - per-bit generate
//            PI [width-1:0] in  - per-bit propagate
//            GT [width-1:0] out - prefix generate from bit 0 to bit i
//            PT [width-1:0] out - prefix propagate from bit 0 to bit i
// Revision : 1.0 - initial release
// ============================================================================
module PrefixAndOr
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] GI,
  input  logic [width-1:0] PI,
  output logic [width-1:0] GT,
  output logic [width-1:0] PT
);

  if (speed == SLOW) begin : g_ripple
    always_comb begin
      GT    = '0;
      PT    = '0;
      GT[0] = GI[0];
      PT[0] = PI[0];
      for (int i = 1; i < width; i++) begin
        GT[i] = GI[i] | (PI[i] & GT[i-1]);
        PT[i] = PI[i] & PT[i-1];
      end
    end
  end else if (speed == MEDIUM) begin : g_sklansky
    localparam int LV = $clog2(width);
    logic [LV:0][width-1:0] gl;
    logic [LV:0][width-1:0] pl;
    always_comb begin
      gl    = '0;
      pl    = '0;
      gl[0] = GI;
      pl[0] = PI;
      for (int l = 0; l < LV; l++) begin
        for (int i = 0; i < width; i++) begin
          // Upper half of each 2^(l+1) block combines with the top bit of
          // the lower half, which already holds that half's full prefix.
          if (((i >> l) & 1) == 1) begin
            gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][((i >> l) << l) - 1]);
            pl[l+1][i] = pl[l][i] & pl[l][((i >> l) << l) - 1];
          end else begin
            gl[l+1][i] = gl[l][i];
            pl[l+1][i] = pl[l][i];
          end
        end
      end
    end
    assign GT = gl[LV];
    assign PT = pl[LV];
  end else begin : g_kogge
    localparam int LV = $clog2(width);
    logic [LV:0][width-1:0] gl;
    logic [LV:0][width-1:0] pl;
    always_comb begin
      gl    = '0;
      pl    = '0;
      gl[0] = GI;
      pl[0] = PI;
      for (int l = 0; l < LV; l++) begin
        for (int i = 0; i < width; i++) begin
          if (i >= (1 << l)) begin
            gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i - (1 << l)]);
            pl[l+1][i] = pl[l][i] & pl[l][i - (1 << l)];
          end else begin
            gl[l+1][i] = gl[l][i];
            pl[l+1][i] = pl[l][i];
          end
        end
      end
    end
    assign GT = gl[LV];
    assign PT = pl[LV];
  end

endmodule : PrefixAndOr
`default_nettype wire

// File: rtl/prefix_and_or_serial.sv
`default_nettype none
// ============================================================================
// Module   : prefix_and_or_serial
// Purpose  : Word-serial prefix AND-OR. Operands arrive LSB-beat first; each
//            beat's group prefix is folded with the carry and accumulated
//            propagate of the earlier beats of the same operand.
// Ports    : CLK, RST            - clock, async active-high reset
//            InValid/InReady     - input beat handshake
//            First/Last          - operand boundary markers
//            CI                  - operand carry-in (First beats only)
//            GI, PI [width-1:0]  - generate / propagate in
//            OutValid/OutReady   - output beat handshake
//            GO, PO [width-1:0]  - folded prefix generate / propagate
//            OutLast             - output beat ends its operand
//            COut                - GO[width-1] (operand carry-out on OutLast)
// Revision : 1.0 - initial release
// ============================================================================
module prefix_and_or_serial
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic             First,
  input  logic             Last,
  input  logic             CI,
  input  logic [width-1:0] GI,
  input  logic [width-1:0] PI,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [width-1:0] GO,
  output logic [width-1:0] PO,
  output logic             OutLast,
  output logic             COut
);

  logic [width-1:0] gt;
  logic [width-1:0] pt;

  PrefixAndOr #(
    .width (width),
    .speed (speed)
  ) u_prefix (
    .GI (GI),
    .PI (PI),
    .GT (gt),
    .PT (pt)
  );

  pao_state_e       state_q, state_d;
  logic             carry_q, carry_d;
  logic             pacc_q,  pacc_d;
  logic             valid_q, valid_d;
  logic [width-1:0] go_q,    go_d;
  logic [width-1:0] po_q,    po_d;
  logic             last_q,  last_d;
  logic             cout_q,  cout_d;

  logic             accept;
  logic             eff_first;
  logic             cin;
  logic             pin;
  logic [width-1:0] go_n;
  logic [width-1:0] po_n;

  // Single output register: room is available when it is empty or being
  // drained this cycle.
  assign InReady = !valid_q | OutReady;
  assign accept  = InValid & InReady;

  // A beat seen while IDLE always starts an operand, even without First.
  assign eff_first = First | (state_q == IDLE);
  assign cin       = eff_first ? CI   : carry_q;
  assign pin       = eff_first ? 1'b1 : pacc_q;
  assign go_n      = gt | (pt & {width{cin}});
  assign po_n      = pt & {width{pin}};

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    pacc_d  = pacc_q;
    valid_d = valid_q;
    go_d    = go_q;
    po_d    = po_q;
    last_d  = last_q;
    cout_d  = cout_q;
    if (accept) begin
      valid_d = 1'b1;
      go_d    = go_n;
      po_d    = po_n;
      last_d  = Last;
      cout_d  = go_n[width-1];
      if (Last) begin
        state_d = IDLE;
        carry_d = 1'b0;
        pacc_d  = 1'b0;
      end else begin
        state_d = BUSY;
        carry_d = go_n[width-1];
        pacc_d  = po_n[width-1];
      end
    end else if (OutReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      pacc_q  <= 1'b0;
      valid_q <= 1'b0;
      go_q    <= '0;
      po_q    <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      pacc_q  <= pacc_d;
      valid_q <= valid_d;
      go_q    <= go_d;
      po_q    <= po_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
    end
  end

  assign OutValid = valid_q;
  assign GO       = go_q;
  assign PO       = po_q;
  assign OutLast  = last_q;
  assign COut     = cout_q;

endmodule : prefix_and_or_serial
`default_nettype wire

// File: tb/tb_prefix_and_or_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefix_and_or_serial
// Purpose  : Self-checking bench; drives one stream into SLOW, MEDIUM and
//            FAST instances and compares each against a bit-serial model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prefix_and_or_serial;
  import lau_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] go;
    logic [W-1:0] po;
    logic         last;
    logic         cout;
  } exp_t;

  typedef struct {
    bit           f;
    bit           l;
    bit           ci;
    bit [W-1:0]   gi;
    bit [W-1:0]   pi;
    exp_t         e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid  = 1'b0;
  logic         first     = 1'b0;
  logic         last      = 1'b0;
  logic         ci        = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] gi        = '0;
  logic [W-1:0] pi        = '0;

  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic         out_last_w  [3];
  logic         cout_w      [3];
  logic [W-1:0] go_w        [3];
  logic [W-1:0] po_w        [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    prefix_and_or_serial #(
      .width (W),
      .speed ((k == 0) ? SLOW : ((k == 1) ? MEDIUM : FAST))
    ) u_dut (
      .CLK      (clk),
      .RST      (rst),
      .InValid  (in_valid),
      .InReady  (in_ready_w[k]),
      .First    (first),
      .Last     (last),
      .CI       (ci),
      .GI       (gi),
      .PI       (pi),
      .OutValid (out_valid_w[k]),
      .OutReady (out_ready),
      .GO       (go_w[k]),
      .PO       (po_w[k]),
      .OutLast  (out_last_w[k]),
      .COut     (cout_w[k])
    );
  end

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  bit   m_busy  = 1'b0;
  bit   m_carry = 1'b0;
  bit   m_pacc  = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s dut%0d: actual=%0h required=%0h", nm, k, act, req);
    end
  endtask

  // Bit-serial reference: walks the operand bit by bit carrying g and p.
  task automatic model_beat(output exp_t e);
    bit eff, c, p;
    eff = first | !m_busy;
    c   = eff ? ci   : m_carry;
    p   = eff ? 1'b1 : m_pacc;
    for (int i = 0; i < W; i++) begin
      c       = gi[i] | (pi[i] & c);
      p       = p & pi[i];
      e.go[i] = c;
      e.po[i] = p;
    end
    e.last = last;
    e.cout = e.go[W-1];
    if (last) begin
      m_busy = 1'b0; m_carry = 1'b0; m_pacc = 1'b0;
    end else begin
      m_busy = 1'b1; m_carry = e.go[W-1]; m_pacc = e.po[W-1];
    end
  endtask

  // Inputs are set after a rising edge; outputs are checked at the falling
  // edge, then the scoreboard is advanced as the DUT will on the next edge.
  task automatic step(input bit use_tab, input exp_t tab_e, output bit acc);
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("InReady", k, in_ready_w[k], (sb.size() == 0) | out_ready);
      if (sb.size() > 0) begin
        chk("OutValid", k, out_valid_w[k], 1);
        chk("GO",       k, go_w[k],        sb[0].go);
        chk("PO",       k, po_w[k],        sb[0].po);
        chk("OutLast",  k, out_last_w[k],  sb[0].last);
        chk("COut",     k, cout_w[k],      sb[0].cout);
      end else begin
        chk("OutValid", k, out_valid_w[k], 0);
      end
    end
    acc = in_valid && ((sb.size() == 0) || out_ready);
    if (sb.size() > 0 && out_ready) void'(sb.pop_front());
    if (acc) begin
      model_beat(e);
      sb.push_back(use_tab ? tab_e : e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit f, bit l, bit c, bit [W-1:0] g, bit [W-1:0] p,
                              bit [W-1:0] ego, bit [W-1:0] epo, bit ecout);
    vec_t v;
    v.f = f; v.l = l; v.ci = c; v.gi = g; v.pi = p;
    v.e.go = ego; v.e.po = epo; v.e.last = l; v.e.cout = ecout;
    return v;
  endfunction

  task automatic drive(input bit f, input bit l, input bit c,
                       input logic [W-1:0] g, input logic [W-1:0] p);
    in_valid = 1'b1; first = f; last = l; ci = c; gi = g; pi = p;
  endtask

  vec_t tab[11];
  exp_t none;
  bit   acc;

  initial begin
    none = '{go: '0, po: '0, last: 1'b0, cout: 1'b0};
    // {First, Last, CI, GI, PI} -> {GO, PO, COut}; OutLast expected = Last.
    tab[0]  = mk(1, 1, 1, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1); // single beat, CI=1
    tab[1]  = mk(1, 0, 0, 8'h80, 8'h00, 8'h80, 8'h00, 1); // beat0: carry=1
    tab[2]  = mk(0, 1, 0, 8'h00, 8'h0F, 8'h0F, 8'h00, 0); // beat1 uses carry
    tab[3]  = mk(1, 0, 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 1); // carry=1 ...
    tab[4]  = mk(1, 1, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 0); // ... restart drops it
    tab[5]  = mk(0, 1, 1, 8'h00, 8'h01, 8'h01, 8'h01, 0); // IDLE w/o First
    tab[6]  = mk(1, 0, 0, 8'h01, 8'hFE, 8'hFF, 8'h00, 1); // 3-beat operand
    tab[7]  = mk(0, 0, 0, 8'h00, 8'hFF, 8'hFF, 8'h00, 1);
    tab[8]  = mk(0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0); // CI ignored mid-op
    tab[9]  = mk(1, 0, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 0); // pacc=1 ...
    tab[10] = mk(0, 1, 0, 8'h40, 8'h3F, 8'h40, 8'h3F, 0); // ... carried into PO

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_OutValid", k, out_valid_w[k], 0);
      chk("rst_GO",       k, go_w[k],        0);
      chk("rst_PO",       k, po_w[k],        0);
      chk("rst_OutLast",  k, out_last_w[k],  0);
      chk("rst_COut",     k, cout_w[k],      0);
      chk("rst_InReady",  k, in_ready_w[k],  1);
    end
    @(posedge clk);
    #1;

    // Directed table, back-to-back beats with OutReady=1.
    out_ready = 1'b1;
    for (int v = 0; v < 11; v++) begin
      drive(tab[v].f, tab[v].l, tab[v].ci, tab[v].gi, tab[v].pi);
      step(1'b1, tab[v].e, acc);
    end
    in_valid = 1'b0;
    step(1'b0, none, acc);
    step(1'b0, none, acc);

    // Backpressure: beat B waits three cycles while beat A is held.
    drive(1, 0, 0, 8'h12, 8'h34);
    step(1'b0, none, acc);
    drive(0, 1, 0, 8'h56, 8'h78);
    out_ready = 1'b0;
    repeat (3) step(1'b0, none, acc);
    out_ready = 1'b1;
    step(1'b0, none, acc);
    in_valid = 1'b0;
    step(1'b0, none, acc);
    step(1'b0, none, acc);

    // Reset mid-operand: beat0 of a 3-beat operand, then async reset.
    drive(1, 0, 0, 8'hFF, 8'h00);
    step(1'b0, none, acc);
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_OutValid", k, out_valid_w[k], 0);
      chk("midrst_GO",       k, go_w[k],        0);
      chk("midrst_PO",       k, po_w[k],        0);
      chk("midrst_COut",     k, cout_w[k],      0);
      chk("midrst_OutLast",  k, out_last_w[k],  0);
    end
    sb.delete();
    m_busy = 1'b0; m_carry = 1'b0; m_pacc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Non-First beat after reset starts a fresh operand with CI=1.
    drive(0, 1, 1, 8'h00, 8'h0F);
    step(1'b1, '{go: 8'h0F, po: 8'h0F, last: 1'b1, cout: 1'b0}, acc);
    in_valid = 1'b0;
    step(1'b0, none, acc);

    // Random operand streams with random bubbles and backpressure.
    for (int op = 0; op < 240; op++) begin
      int nb;
      bit c0;
      nb = $urandom_range(1, 6);
      c0 = 1'($urandom_range(0, 1));
      for (int b = 0; b < nb; b++) begin
        int tries;
        bit f;
        f = (b == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
        first = f;
        last  = (b == nb - 1);
        ci    = f ? c0 : 1'($urandom_range(0, 1));
        gi    = W'($urandom_range(0, 255));
        pi    = W'($urandom_range(0, 255));
        tries = 0;
        acc   = 1'b0;
        while (!acc) begin
          in_valid  = ($urandom_range(0, 4) != 0);
          out_ready = ($urandom_range(0, 3) != 0);
          step(1'b0, none, acc);
          tries++;
          if (!acc && tries > 100) begin
            chk("accept_timeout", 0, 0, 1);
            break;
          end
        end
      end
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step(1'b0, none, acc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_prefix_and_or_serial
`default_nettype wire

// File: doc/prefix_and_or_serial.md
Name: prefix_and_or_serial

Overview:
- Word-serial prefix AND-OR unit for operands wider than one datapath word.
- Operands arrive as `width`-bit beats, least-significant first, over a valid/ready stream.
- Each beat computes the combinational group prefix (`PrefixAndOr`) and folds in the running carry and accumulated propagate from earlier beats, so the adder/comparator datapaths behind it can span arbitrary operand widths.
- Results leave through a single registered output stage with backpressure.

Parameters:
- width, 8, beat width in bits (>= 2).
- speed, lau_pkg::FAST, prefix-tree topology passed to `PrefixAndOr`.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-high reset.
- InValid  input  1  input beat valid.
- InReady  output  1  input beat accepted when InValid & InReady.
- First  input  1  beat is the least-significant beat of an operand.
- Last  input  1  beat is the most-significant beat of an operand.
- CI  input  1  operand carry-in; sampled only on a First beat.
- GI  input  width  generate in.
- PI  input  width  propagate in.
- OutValid  output  1  output beat valid.
- OutReady  input  1  downstream accepts output.
- GO  output  width  prefix generate including carry-in and earlier beats.
- PO  output  width  prefix propagate from operand bit 0 up to each bit.
- OutLast  output  1  output beat is the last beat of its operand.
- COut  output  1  GO[width-1] of the beat; operand carry-out when OutLast=1.

Behaviour:
- Reset: OutValid=0, GO=0, PO=0, OutLast=0, COut=0. State=IDLE, carry reg=0, pacc reg=0. InReady=1 after reset.
- Handshake:
  - InReady = !OutValid | OutReady, combinational from OutValid/OutReady only.
  - InReady never depends on InValid.
  - Accept = InValid & InReady.
- Per accepted beat (combinational, then registered):
  - GT/PT = PrefixAndOr(GI, PI).
  - cin = effective-first ? CI : carry.
  - pin = effective-first ? 1 : pacc.
  - GO_n = GT | (PT & {width{cin}}).
  - PO_n = PT & {width{pin}}.
  - On the next clock edge: GO/PO := GO_n/PO_n, COut := GO_n[width-1], OutLast := Last, OutValid := 1.
- Latency: 1 cycle from accept to OutValid. Throughput: 1 beat/cycle when OutReady=1.
- OutValid clears on an OutReady handshake with no new accept.
- Outputs hold stable while OutValid & !OutReady.
- State machine:
  - effective-first = First | (state==IDLE).
  - IDLE: an accept with Last=0 moves to BUSY and sets carry := GO_n[width-1], pacc := PO_n[width-1].
  - IDLE: an accept with Last=1 (single-beat operand) stays in IDLE.
  - BUSY: an accept with Last=0 stays in BUSY and updates carry/pacc.
  - BUSY: an accept with Last=1 returns to IDLE; carry and pacc clear to 0.
  - First in BUSY restarts the operand: old carry/pacc are discarded and CI is used.
  - A beat without First in IDLE is treated as First.
  - First & Last together: a single-beat operand, identical to `PrefixAndOrCfast` behaviour.
- No state change without an accept. InValid without InReady has no effect.
- Simultaneous output handshake and new accept: the register is overwritten, OutValid stays 1, no bubble.
- Reset mid-operand: immediate return to IDLE, all registers cleared, any in-flight output dropped.

Decomposition:
- lau_pkg: reuse speed_e. Add a state enum type (IDLE, BUSY) for this block.
- Sub-module: one instance of the existing `PrefixAndOr`.
- The carry-fold logic, FSM and output register stay local; no further sub-modules.

Test Plan (width=8):
- Single beat, First=Last=1, GI=0x00, PI=0xFF, CI=1 -> next cycle OutValid=1, GO=0xFF, PO=0xFF, COut=1, OutLast=1.
- Two beats:
  - Beat0 First=1, GI=0x80, PI=0x00, CI=0 -> GO=0x80, PO=0x00, COut=1.
  - Beat1 Last=1, GI=0x00, PI=0x0F -> GO=0x0F, PO=0x00, COut=0, OutLast=1; FSM back to IDLE.
- Backpressure: hold OutReady=0 for 3 cycles with InValid=1 -> InReady=0, GO/PO/COut unchanged. Raise OutReady -> next beat accepted the same cycle, no lost or duplicated beat.
- Restart: Beat0 First=1, GI=0xFF, PI=0x00 (carry=1). Then First=1, Last=1, GI=0x00, PI=0xFF, CI=0 -> GO=0x00, COut=0 (stale carry ignored).
- Reset mid-operand: assert RST after beat0 of a 3-beat operand -> outputs at reset values. Next beat without First is treated as First with CI.
- Random streams for speed SLOW/MEDIUM/FAST, random beat counts 1-6 and random OutReady -> GO/PO/COut match a bit-serial reference model beat-for-beat.
